gray_updown_counter: RTL and testbench

//   Parametrised up/down counter that holds its state in binary and presents it in both binary and Gray code.
//   - Gray-coded value is loadable; it is converted to binary (g2b) on entry.
//   - Both output codes are registered, glitch-free and change together.
//   - Wrap or saturate selectable at elaboration.
//   - Sits in front of async-crossing pointers and rotary/position logic that consume Gray values.

---
 rtl/gray_updown_counter.sv | 74 +++++++
 tb/tb_gray_updown_counter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// Up/down counter holding its state in binary and presenting registered binary and Gray views.
// The counter is loadable from a Gray value, and it either wraps or saturates at the limits (chosen by WRAP).
module gray_updown_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap_p,
  output logic             sat
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] step_bin;
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;
  logic             sat_nxt;
  logic             limit_hit;
  logic             load_at_limit;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(load_gray >> i);
    end
  end

  assign step_bin      = up ? (bin_out + ONE) : (bin_out - ONE);
  assign limit_hit     = up ? (&bin_out) : (~|bin_out);
  assign load_at_limit = up ? (&load_bin) : (~|load_bin);

  always_comb begin
    bin_nxt  = bin_out;
    wrap_nxt = 1'b0;
    sat_nxt  = sat;
    if (load) begin
      bin_nxt = load_bin;
      sat_nxt = !WRAP && load_at_limit;
    end else if (en) begin
      if (limit_hit && !WRAP) begin
        sat_nxt = 1'b1;
      end else begin
        bin_nxt  = step_bin;
        wrap_nxt = WRAP && limit_hit;
        sat_nxt  = 1'b0;
      end
    end
  end

  // Both codes come from the same next value so they always update on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out  <= '0;
      gray_out <= '0;
      wrap_p   <= 1'b0;
      sat      <= 1'b0;
    end else begin
      bin_out  <= bin_nxt;
      gray_out <= bin_nxt ^ (bin_nxt >> 1);
      wrap_p   <= wrap_nxt;
      sat      <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: three instances (4-bit wrap, 4-bit saturate, 8-bit wrap)
// checked every cycle against an integer model, plus hand-computed directed expectations.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] lg8 = 8'h00;

  logic [3:0] bin_a, gray_a, bin_b, gray_b;
  logic [7:0] bin_c, gray_c;
  logic       wrap_a, sat_a, wrap_b, sat_b, wrap_c, sat_c;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  int m_bin[3];
  int m_wrap[3];
  int m_sat[3];
  int last_dgray[3];
  int widths[3] = '{4, 4, 8};
  bit wraps[3]  = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(4), .WRAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg8[3:0]),
    .bin_out(bin_a), .gray_out(gray_a), .wrap_p(wrap_a), .sat(sat_a));

  gray_updown_counter #(.WIDTH(4), .WRAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg8[3:0]),
    .bin_out(bin_b), .gray_out(gray_b), .wrap_p(wrap_b), .sat(sat_b));

  gray_updown_counter #(.WIDTH(8), .WRAP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(lg8),
    .bin_out(bin_c), .gray_out(gray_c), .wrap_p(wrap_c), .sat(sat_c));

  // Gray decode by search: the binary value whose Gray image matches
  function automatic int g2bSearch(input int g, input int w);
    for (int b = 0; b < (1 << w); b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic int grayOf(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic getDut(input int k, output int b, output int g, output int w, output int s);
    case (k)
      0: begin b = int'(bin_a); g = int'(gray_a); w = int'(wrap_a); s = int'(sat_a); end
      1: begin b = int'(bin_b); g = int'(gray_b); w = int'(wrap_b); s = int'(sat_b); end
      default: begin b = int'(bin_c); g = int'(gray_c); w = int'(wrap_c); s = int'(sat_c); end
    endcase
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input int k);
    int maxv;
    maxv = (1 << widths[k]) - 1;
    if (rst) begin
      m_bin[k] = 0; m_wrap[k] = 0; m_sat[k] = 0;
    end else if (load) begin
      m_bin[k]  = g2bSearch(int'(lg8) & maxv, widths[k]);
      m_wrap[k] = 0;
      m_sat[k]  = (!wraps[k] && ((up && m_bin[k] == maxv) || (!up && m_bin[k] == 0))) ? 1 : 0;
    end else if (en) begin
      m_wrap[k] = 0;
      if ((up && m_bin[k] == maxv) || (!up && m_bin[k] == 0)) begin
        if (wraps[k]) begin
          m_bin[k] = up ? 0 : maxv;
          m_wrap[k] = 1;
        end else begin
          m_sat[k] = 1;
        end
      end else begin
        m_bin[k] = up ? m_bin[k] + 1 : m_bin[k] - 1;
        m_sat[k] = 0;
      end
    end else begin
      m_wrap[k] = 0;
    end
  endtask

  // Model advance and per-cycle comparison for all three instances
  always @(posedge clk) begin
    int old_bin[3];
    bit stepped;
    int db, dg, dw, ds;
    stepped = !rst && !load && en;
    for (int k = 0; k < 3; k++) begin
      old_bin[k] = m_bin[k];
      modelStep(k);
    end
    if (rst) started = 1'b1;
    #1;
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        getDut(k, db, dg, dw, ds);
        checkValue($sformatf("bin[%0d]", k), db, m_bin[k]);
        checkValue($sformatf("gray[%0d]", k), dg, grayOf(m_bin[k]));
        checkValue($sformatf("wrap_p[%0d]", k), dw, m_wrap[k]);
        checkValue($sformatf("sat[%0d]", k), ds, m_sat[k]);
        if (stepped && old_bin[k] != m_bin[k])
          checkValue($sformatf("gray_toggle[%0d]", k), $countones(dg ^ last_dgray[k]), 1);
        last_dgray[k] = dg;
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit e, input bit u, input bit l, input logic [7:0] g);
    @(negedge clk);
    rst = r; en = e; up = u; load = l; lg8 = g;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Literal expectation checked against both the DUT and the model
  task automatic checkOutput(input int k, input string name, input int eb, input int eg,
                             input int ew, input int es);
    int db, dg, dw, ds;
    getDut(k, db, dg, dw, ds);
    checkValue({name, ".bin"}, db, eb);
    checkValue({name, ".gray"}, dg, eg);
    checkValue({name, ".wrap_p"}, dw, ew);
    checkValue({name, ".sat"}, ds, es);
    checkValue({name, ".model_bin"}, m_bin[k], eb);
    checkValue({name, ".model_sat"}, m_sat[k], es);
  endtask

  initial begin
    logic [3:0] lg_vec[5]  = '{4'b1011, 4'b0111, 4'b0101, 4'b1100, 4'b1111};
    logic [3:0] bin_vec[5] = '{4'b1101, 4'b0101, 4'b0110, 4'b1000, 4'b1010};

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput(0, "reset_a", 0, 0, 0, 0);
    checkOutput(1, "reset_b", 0, 0, 0, 0);
    checkOutput(2, "reset_c", 0, 0, 0, 0);

    $display("[TB] load conversion");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, {4'h0, lg_vec[i]});
      tick();
      checkOutput(0, $sformatf("load%0d", i), int'(bin_vec[i]), int'(lg_vec[i]), 0, 0);
    end

    $display("[TB] up sweep");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    repeat (15) tick();
    checkOutput(0, "up15_a", 15, 8, 0, 0);
    checkOutput(1, "up15_b", 15, 8, 0, 0);
    tick();
    checkOutput(0, "up16_a", 0, 0, 1, 0);
    checkOutput(1, "up16_b", 15, 8, 0, 1);
    checkOutput(2, "up16_c", 16, 24, 0, 0);

    $display("[TB] down from zero");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput(0, "down1_a", 15, 8, 1, 0);
    checkOutput(1, "down1_b", 0, 0, 0, 1);
    tick();
    checkOutput(0, "down2_a", 14, 9, 0, 0);
    checkOutput(1, "down2_b", 0, 0, 0, 1);

    $display("[TB] saturate");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h08);
    tick();
    checkOutput(0, "ldmax_a", 15, 8, 0, 0);
    checkOutput(1, "ldmax_b", 15, 8, 0, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h08);
    tick();
    checkOutput(0, "wrap_after_load_a", 0, 0, 1, 0);
    checkOutput(1, "satup1_b", 15, 8, 0, 1);
    tick();
    tick();
    checkOutput(0, "up3_a", 2, 3, 0, 0);
    checkOutput(1, "satup3_b", 15, 8, 0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h08);
    tick();
    checkOutput(0, "dirchg_a", 1, 1, 0, 0);
    checkOutput(1, "unsat_b", 14, 9, 0, 0);

    $display("[TB] load priority and mid-count reset");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h06);
    tick();
    checkOutput(0, "load_pri_a", 4, 6, 0, 0);
    checkOutput(1, "load_pri_b", 4, 6, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h06);
    tick();
    tick();
    checkOutput(0, "count6_a", 6, 5, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h06);
    tick();
    checkOutput(0, "midrst_a", 0, 0, 0, 0);
    checkOutput(1, "midrst_b", 0, 0, 0, 0);
    checkOutput(2, "midrst_c", 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h06);
    tick();
    checkOutput(0, "resume_a", 1, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput(0, "hold_a", 1, 1, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                    8'($urandom_range(0, 255)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
